// File: rtl/digit_scan_ctrl.sv
// Four-digit 7-segment scan controller: drives the digit mux selects, decodes the
// returned digit and time-multiplexes active-low anodes with a blanking gap per slot.
module digit_scan_ctrl #(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] mux_y,
  input  logic [3:0] blank_mask,
  input  logic [3:0] dp_mask,
  output logic       sel_s0,
  output logic       sel_s1,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       slot_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    d, d_nxt;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt, tick_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // The select lines come straight from the digit-index flops, so they are registered too.
  assign sel_s0 = d[1];
  assign sel_s1 = d[0];

  always_comb begin
    // NOTE: every next-value signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d;
    an_nxt    = an;
    seg_nxt   = seg;
    dp_nxt    = dp;
    tick_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        d_nxt   = 2'd0;
        an_nxt  = 4'hF;
        if (en) state_nxt = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          d_nxt     = 2'd0;
          an_nxt    = 4'hF;
        end else if (cnt == BLANK_LAST) begin
          // Capture edge: mux_y has had at least two cycles to settle on the new select.
          seg_nxt   = decode(mux_y);
          dp_nxt    = ~dp_mask[d];
          an_nxt    = 4'hF;
          an_nxt[d] = blank_mask[d];
          cnt_nxt   = '0;
          state_nxt = DRIVE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          d_nxt     = 2'd0;
          an_nxt    = 4'hF;
        end else if (cnt == DRIVE_LAST) begin
          an_nxt    = 4'hF;
          d_nxt     = d + 2'd1;
          tick_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BLANK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      d         <= 2'd0;
      an        <= 4'hF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d         <= d_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
      slot_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: a time-based reference model derives the
// expected display from the number of edges since the scan was enabled.
module tb_digit_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] mux_y, blank_mask, dp_mask;
  logic       sel_s0, sel_s1, dp, slot_tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] mux_in [4];

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since enable (-1 = parked), held seg/dp, captured blank bit.
  int         m_k;
  logic [6:0] m_seg;
  logic       m_dp;
  logic       m_cap_blank;
  int         ticks;

  always #5 clk = ~clk;

  assign mux_y = mux_in[{sel_s0, sel_s1}];

  digit_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .mux_y(mux_y), .blank_mask(blank_mask),
    .dp_mask(dp_mask), .sel_s0(sel_s0), .sel_s1(sel_s1), .an(an), .seg(seg),
    .dp(dp), .slot_tick(slot_tick)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_k         = -1;
    m_seg       = 7'h7F;
    m_dp        = 1'b1;
    m_cap_blank = 1'b0;
  endtask

  // One clock edge: predict from inputs seen at the edge, then compare just after it.
  task automatic step();
    int         ph, dg;
    logic [3:0] exp_an;
    logic [1:0] exp_sel;
    logic       exp_tick;
    exp_an   = 4'hF;
    exp_sel  = 2'd0;
    exp_tick = 1'b0;
    if (m_k < 0) begin
      if (en) m_k = 0;
    end else if (!en) begin
      m_k = -1;
    end else begin
      m_k++;
      ph       = m_k % SD;
      dg       = (m_k / SD) % 4;
      exp_sel  = 2'(dg);
      exp_tick = (ph == 0);
      if (ph == BC) begin
        m_seg       = TBL[mux_in[dg]];
        m_dp        = ~dp_mask[dg];
        m_cap_blank = blank_mask[dg];
      end
      if (ph >= BC && !m_cap_blank) exp_an[dg] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (slot_tick === 1'b1) ticks++;
    check("an", 8'(an), 8'(exp_an));
    check("sel", 8'({sel_s0, sel_s1}), 8'(exp_sel));
    check("slot_tick", 8'(slot_tick), 8'(exp_tick));
    check("seg", 8'(seg), 8'(m_seg));
    check("dp", 8'(dp), 8'(m_dp));
    check("one_anode", 8'($countones(~an) <= 1), 8'd1);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    blank_mask = 4'h0;
    dp_mask    = 4'h0;
    mux_in     = '{4'd1, 4'd2, 4'd3, 4'd4};
    model_reset();
    #3;
    check("rst_an", 8'(an), 8'hF);
    check("rst_seg", 8'(seg), 8'h7F);
    check("rst_dp", 8'(dp), 8'h1);
    check("rst_sel", 8'({sel_s0, sel_s1}), 8'h0);
    check("rst_tick", 8'(slot_tick), 8'h0);
    #9 rst = 1'b0;

    // Asynchronous reset in the middle of a DRIVE phase.
    en = 1'b1;
    repeat (6) step();
    check("pre_rst_an", 8'(an), 8'hE);
    #2 rst = 1'b1;
    #1;
    check("arst_an", 8'(an), 8'hF);
    check("arst_seg", 8'(seg), 8'h7F);
    check("arst_dp", 8'(dp), 8'h1);
    check("arst_sel", 8'({sel_s0, sel_s1}), 8'h0);
    check("arst_tick", 8'(slot_tick), 8'h0);
    #1 rst = 1'b0;
    model_reset();

    // Plain scan of digits 1,2,3,4.
    repeat (4 * SD) step();

    // Decoder sweep: every code is captured in exactly one slot.
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < 4; i++) mux_in[i] = 4'(v);
      repeat (SD) step();
    end
    mux_in = '{4'd1, 4'd2, 4'd3, 4'd4};

    // Masks.
    blank_mask = 4'b0100;
    repeat (4 * SD) step();
    blank_mask = 4'b0000;
    dp_mask    = 4'b0001;
    repeat (4 * SD) step();
    dp_mask    = 4'b0000;

    // Disable during digit 1 DRIVE, then re-enable.
    for (int n = 0; n < 4 * SD && !(m_k >= 0 && (m_k % (4 * SD)) == SD + 4); n++) step();
    check("mid_drive_d1", 8'(an), 8'hD);
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (3) step();
    check("reenable_an", 8'(an), 8'hE);

    // Three full rotations from a fresh start.
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    ticks = 0;
    repeat (12 * SD) step();
    check("tick_count", 8'(ticks), 8'd12);

    // Randomised inputs, masks and occasional enable drops.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) mux_in[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
